mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// One transaction in flight; response returns MEM_LAT cycles after issue.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        own_q, own_d;
    logic        we_q, we_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        pick_d;

    // last_q/own_q: 1 = data port, 0 = fetch port
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        own_d      = own_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_size   = 2'b00;
        mem_addr   = '0;
        mem_wdata  = '0;
        pick_d     = d_req & (~if_req | ~last_q);
        case (state_q)
            IDLE: begin
                if (!reset && (if_req || d_req)) begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                    last_d  = pick_d;
                    own_d   = pick_d;
                    we_d    = pick_d & d_we;
                    mem_en  = 1'b1;
                    if (pick_d) begin
                        d_gnt     = 1'b1;
                        mem_we    = d_we;
                        mem_size  = d_size;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                    end else begin
                        if_gnt   = 1'b1;
                        mem_size = 2'b10;
                        mem_addr = if_addr;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                    // a reset in this cycle drops the response
                    if (!reset) begin
                        if (own_q) begin
                            d_rvalid  = 1'b1;
                            d_rdata_d = we_q ? 32'd0 : mem_rdata;
                        end else begin
                            if_rvalid  = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_rdata = if_rdata_d;
    assign d_rdata  = d_rdata_d;
    assign busy     = (state_q == WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_q     <= 1'b0;
            own_q      <= 1'b0;
            we_q       <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            own_q      <= own_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1..3) share one stimulus set.
// Each scenario checks the instance whose latency it targets.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic        if_gnt    [1:3];
    logic        if_rvalid [1:3];
    logic [31:0] if_rdata  [1:3];
    logic        d_gnt     [1:3];
    logic        d_rvalid  [1:3];
    logic [31:0] d_rdata   [1:3];
    logic        mem_en    [1:3];
    logic        mem_we    [1:3];
    logic [1:0]  mem_size  [1:3];
    logic [31:0] mem_addr  [1:3];
    logic [31:0] mem_wdata [1:3];
    logic        busy      [1:3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        mem_arbiter #(.MEM_LAT(g), .AW(32)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_size    (d_size),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_size  (mem_size[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_req();
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 2'b00;
        if_addr = 32'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
    endtask

    task automatic do_reset();
        nxt();
        reset = 1'b1;
        clr_req();
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        mem_rdata = 32'd0;
        clr_req();
        nxt();

        // request raised while reset is still high: no grant
        if_req  = 1'b1;
        if_addr = 32'h0040_0000;
        #2;
        chk("rst_if_gnt", if_gnt[1], 0);
        chk("rst_mem_en", mem_en[1], 0);
        chk("rst_busy", busy[1], 0);
        chk("rst_if_rdata", if_rdata[1], 0);
        chk("rst_d_rdata", d_rdata[1], 0);
        chk("rst_rvalid", if_rvalid[1] | d_rvalid[1], 0);

        // single fetch, MEM_LAT=1
        nxt();
        reset     = 1'b0;
        mem_rdata = 32'h2008_0005;
        #2;
        chk("f_gnt", if_gnt[1], 1);
        chk("f_mem_en", mem_en[1], 1);
        chk("f_mem_addr", mem_addr[1], 32'h0040_0000);
        chk("f_mem_size", mem_size[1], 2'b10);
        chk("f_mem_we", mem_we[1], 0);
        chk("f_mem_wdata", mem_wdata[1], 0);
        chk("f_busy0", busy[1], 0);
        nxt();
        if_req = 1'b0;
        #2;
        chk("f_rvalid", if_rvalid[1], 1);
        chk("f_rdata", if_rdata[1], 32'h2008_0005);
        chk("f_busy1", busy[1], 1);
        chk("f_mem_en1", mem_en[1], 0);
        chk("f_mem_addr1", mem_addr[1], 0);
        nxt();
        mem_rdata = 32'h1111_2222;
        #2;
        chk("f_rvalid2", if_rvalid[1], 0);
        chk("f_rdata_hold", if_rdata[1], 32'h2008_0005);
        chk("f_busy2", busy[1], 0);

        // both held, MEM_LAT=2: D,F,D,F every 3 cycles
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        d_req   = 1'b1;
        d_addr  = 32'h0000_0100;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) nxt();
            #2;
            chk("rr_d_gnt", d_gnt[2], (k % 3 == 0) && ((k / 3) % 2 == 0));
            chk("rr_if_gnt", if_gnt[2], (k % 3 == 0) && ((k / 3) % 2 == 1));
        end
        clr_req();

        // load then store on MEM_LAT=1
        do_reset();
        d_req     = 1'b1;
        d_addr    = 32'h0000_0020;
        mem_rdata = 32'hCAFE_F00D;
        #2;
        chk("ld_gnt", d_gnt[1], 1);
        chk("ld_mem_we", mem_we[1], 0);
        nxt();
        d_req = 1'b0;
        #2;
        chk("ld_rvalid", d_rvalid[1], 1);
        chk("ld_rdata", d_rdata[1], 32'hCAFE_F00D);
        chk("ld_no_if", if_rvalid[1], 0);
        nxt();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_size  = 2'b00;
        d_addr  = 32'h1000_0004;
        d_wdata = 32'hDEAD_BEEF;
        #2;
        chk("st_gnt", d_gnt[1], 1);
        chk("st_mem_we", mem_we[1], 1);
        chk("st_mem_size", mem_size[1], 2'b00);
        chk("st_mem_addr", mem_addr[1], 32'h1000_0004);
        chk("st_mem_wdata", mem_wdata[1], 32'hDEAD_BEEF);
        chk("st_rdata_hold", d_rdata[1], 32'hCAFE_F00D);
        nxt();
        clr_req();
        #2;
        chk("st_rvalid", d_rvalid[1], 1);
        chk("st_rdata", d_rdata[1], 0);
        chk("st_mem_we1", mem_we[1], 0);
        chk("st_mem_wdata1", mem_wdata[1], 0);
        nxt();
        #2;
        chk("st_rvalid2", d_rvalid[1], 0);
        chk("st_busy2", busy[1], 0);

        // reset one cycle after grant, MEM_LAT=3
        do_reset();
        d_req     = 1'b1;
        d_addr    = 32'h0000_0040;
        mem_rdata = 32'h55AA_55AA;
        #2;
        chk("ra_gnt", d_gnt[3], 1);
        nxt();
        d_req = 1'b0;
        reset = 1'b1;
        #2;
        chk("ra_busy", busy[3], 1);
        chk("ra_rv1", d_rvalid[3], 0);
        nxt();
        reset  = 1'b0;
        d_req  = 1'b1;
        d_addr = 32'h0000_0080;
        #2;
        chk("ra_regnt", d_gnt[3], 1);
        chk("ra_readdr", mem_addr[3], 32'h0000_0080);
        chk("ra_rv2", d_rvalid[3], 0);
        nxt();
        d_req = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            if (k > 3) nxt();
            #2;
            chk("ra_rv", d_rvalid[3], k == 5);
        end

        // data pulse during WAIT is dropped, MEM_LAT=3
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        #2;
        chk("pw_if_gnt", if_gnt[3], 1);
        nxt();
        if_req = 1'b0;
        d_req  = 1'b1;
        d_addr = 32'h0000_0400;
        #2;
        chk("pw_d_gnt", d_gnt[3], 0);
        chk("pw_mem_en", mem_en[3], 0);
        for (int k = 2; k <= 6; k++) begin
            nxt();
            d_req = 1'b0;
            #2;
            chk("pw_d_gnt_k", d_gnt[3], 0);
            chk("pw_mem_en_k", mem_en[3], 0);
            chk("pw_if_rv_k", if_rvalid[3], k == 3);
            chk("pw_d_rv_k", d_rvalid[3], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
